divider: RTL and testbench
==========================

Name: divider

Overview:
- Sequential restoring unsigned integer divider. It is the inverse companion of the 24-bit shift-add multiplier in the floating-point datapath.
- Computes quotient and remainder of two WIDTH-bit operands, producing one quotient bit per clock.
- Uses the same start / out_en handshake style as the multiplier. The floating-point divide path will drive it for mantissa division.

Parameters:
WIDTH, 24, operand/quotient/remainder width in bits (minimum 2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled on rising edge while busy=0
x  input  WIDTH  dividend (unsigned), captured when start accepted
y  input  WIDTH  divisor (unsigned), captured when start accepted
q  output  WIDTH  quotient, registered
r  output  WIDTH  remainder, registered
out_en  output  1  one-cycle pulse: q/r/div_by_zero valid and newly updated
busy  output  1  high while a division is in progress
div_by_zero  output  1  high with the result of a y=0 operation; held until next result

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled only on the rising edge of clk.
- While reset=1: state=IDLE, and q, r, out_en, busy, div_by_zero, internal iteration counter and working registers are all 0. Reset dominates start.
- States:
  - IDLE: busy=0. If start=1, latch x and y. If y=0, go to DONE. Otherwise clear partial remainder, counter=0, go to CALC, busy=1.
  - CALC: one restoring step per edge.
    - Partial remainder PR (WIDTH+1 bits) = {PR, MSB of dividend shift register}.
    - If PR >= divisor: PR -= divisor and shift 1 into quotient; else shift 0.
    - Counter increments each step.
    - On the WIDTH-th step: write final quotient/remainder to q/r, div_by_zero=0, out_en=1, busy=0, go to DONE.
  - DONE: out_en=1 for exactly this cycle. On the next edge, out_en=0. If start=1 on that edge it is accepted exactly as in IDLE; otherwise go to IDLE.
- Divide by zero (accepted on edge N):
  - At edge N+1: q=all ones, r=x, div_by_zero=1, out_en=1.
  - busy is high only between edges N and N+1.
- Latency for y≠0, start accepted on edge N:
  - busy=1 from edge N to edge N+WIDTH.
  - out_en=1 between edges N+WIDTH and N+WIDTH+1.
- q, r and div_by_zero hold their last result until the next out_en. They do not change during CALC; working registers are internal.
- start while busy=1 is ignored. No queueing; x/y changes during CALC have no effect.
- start held high continuously: a new operation is accepted every WIDTH+1 edges (y≠0).
- Arithmetic: unsigned only.
  - Results: q = floor(x/y) and r = x mod y.
  - r < y is always guaranteed.
  - x < y gives q=0, r=x.
- The PR compare must use WIDTH+1 bits so that a divisor with its MSB set does not overflow.
- Reset mid-operation: the operation is abandoned, no out_en is produced, and outputs return to reset values on that edge. The next start after reset deasserts behaves normally.

Test Plan:
- Reset 1 for 3 edges, then 0; x=91, y=10, start=1 for one cycle (accepted edge N) -> busy 1 from N to N+24, out_en single pulse at N+24, q=9, r=1, div_by_zero=0.
- x=910 then x=0xFFFFFF with y=1, x=5 with y=7 (separate ops) -> q=91,r=0; q=0xFFFFFF,r=0; q=0,r=5; each out_en exactly one cycle.
- x=0x800000, y=0xC00001 and x=0xFFFFFF, y=0x800000 -> q=0,r=0x800000; q=1,r=0x7FFFFF (MSB-set divisor check).
- x=91, y=0 -> out_en at N+1, q=0xFFFFFF, r=91, div_by_zero=1. Then 100/3 -> q=33, r=1, div_by_zero=0.
- Start 91/10. At N+5 pulse start with x=7, y=2 -> second start ignored, result 9/1. Assert reset at N+12 -> q=r=0, busy=0, out_en never pulses for that op.
- start held high, operands 91/10 then 50/7 switched during DONE cycle -> out_en at N+24 (9/1) and N+49 (q=7,r=1); no missed or duplicated pulses.

Source files
------------

// File: rtl/divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock.
// Operands are captured on an accepted start. A busy window and a
// one-cycle out_en pulse frame each result.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       request, accepted in IDLE or DONE
//   x, y        dividend / divisor, captured when start is accepted
//   q, r        registered quotient / remainder
//   out_en      one-cycle pulse when q/r/div_by_zero are newly updated
//   busy        high while a division is in progress
//   div_by_zero set with the result of a y=0 operation
module divider #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             out_en,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  // DIVZ spends one cycle producing the divide-by-zero result.
  typedef enum logic [1:0] {IDLE, CALC, DIVZ, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;       // dividend shift register, refills with quotient bits
  logic [WIDTH-1:0] dvs;       // latched divisor
  logic [WIDTH-1:0] pr;        // partial remainder, always < dvs between steps
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   pr_shift;
  logic             ge;
  logic [WIDTH-1:0] pr_next;
  logic [WIDTH-1:0] dvd_next;

  // One restoring step. The compare is WIDTH+1 bits wide so that a divisor
  // with its MSB set cannot overflow. The difference always fits in WIDTH
  // bits, so the subtraction can drop the top bit.
  always_comb begin
    pr_shift = {pr, dvd[WIDTH-1]};
    ge       = (pr_shift >= {1'b0, dvs});
    pr_next  = ge ? (pr_shift[WIDTH-1:0] - dvs) : pr_shift[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], ge};
  end

  // State machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      pr          <= '0;
      cnt         <= '0;
      q           <= '0;
      r           <= '0;
      out_en      <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      out_en <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd   <= x;
            dvs   <= y;
            pr    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= (y == '0) ? DIVZ : CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          pr  <= pr_next;
          dvd <= dvd_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            q           <= dvd_next;
            r           <= pr_next;
            div_by_zero <= 1'b0;
            out_en      <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
        end
        DIVZ: begin
          q           <= '1;
          r           <= dvd;
          div_by_zero <= 1'b1;
          out_en      <= 1'b1;
          busy        <= 1'b0;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed scenarios plus randomized
// operands compared against a plain-arithmetic reference model.
module tb_divider;

  localparam int unsigned W = 24;
  localparam logic [W-1:0] ONES = '1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         out_en;
  logic         busy;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  // Last result seen, used to confirm outputs hold until the next out_en.
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
    .q(q), .r(r), .out_en(out_en), .busy(busy), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: unsigned floor division, all-ones / dividend for y=0.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? ONES : W'(a / b);
  endfunction
  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? a : W'(a % b);
  endfunction

  // Issues one start and observes the DUT for a fixed window.
  // k=0 is the sample just after the accepting edge N; k is edges after N.
  task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                        output int lat, output int npulse, output int busylen,
                        output logic [W-1:0] qo, output logic [W-1:0] ro,
                        output logic dz, output logic [W-1:0] q_pre,
                        output logic [W-1:0] r_pre);
    @(negedge clk);
    x = xv; y = yv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; npulse = 0; busylen = 0;
    qo = '0; ro = '0; dz = 1'b0;
    q_pre = q; r_pre = r;
    for (int k = 0; k <= int'(W) + 3; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (busy) busylen++;
      if (out_en) begin
        npulse++;
        if (lat < 0) begin
          lat = k; qo = q; ro = r; dz = div_by_zero;
        end
      end
    end
  endtask

  // Compares one observed operation against the model.
  task automatic test_op(input string name, input logic [W-1:0] xv, input logic [W-1:0] yv);
    int lat, npulse, busylen, exp_lat;
    logic [W-1:0] qo, ro, qp, rp, eq, er;
    logic dz;
    run_op(xv, yv, lat, npulse, busylen, qo, ro, dz, qp, rp);
    exp_lat = (yv == '0) ? 1 : int'(W);
    eq = ref_q(xv, yv);
    er = ref_r(xv, yv);
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (npulse !== 1) begin
      errors++; $display("FAIL %s pulse count: got %0d expected 1", name, npulse);
    end
    checks++;
    if (busylen !== exp_lat) begin
      errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, busylen, exp_lat);
    end
    checks++;
    if (qo !== eq || ro !== er) begin
      errors++; $display("FAIL %s q/r: got %0h/%0h expected %0h/%0h", name, qo, ro, eq, er);
    end
    checks++;
    if (dz !== (yv == '0)) begin
      errors++; $display("FAIL %s div_by_zero: got %0b expected %0b", name, dz, (yv == '0));
    end
    checks++;
    if (qp !== last_q || rp !== last_r) begin
      errors++; $display("FAIL %s hold: got %0h/%0h expected %0h/%0h", name, qp, rp, last_q, last_r);
    end
    last_q = eq;
    last_r = er;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q !== '0 || r !== '0 || out_en !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: got q=%0h r=%0h oe=%0b busy=%0b dz=%0b expected all 0",
               q, r, out_en, busy, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    test_op("91/10", W'(91), W'(10));
    test_op("910/1", W'(910), W'(1));
    test_op("max/1", ONES, W'(1));
    test_op("5/7", W'(5), W'(7));
  endtask

  task automatic test_msb_divisor();
    test_op("800000/C00001", W'(24'h800000), W'(24'hC00001));
    test_op("FFFFFF/800000", ONES, W'(24'h800000));
    test_op("FFFFFF/FFFFFF", ONES, ONES);
  endtask

  task automatic test_div_zero();
    test_op("91/0", W'(91), W'(0));
    test_op("100/3", W'(100), W'(3));
    test_op("0/0", W'(0), W'(0));
    test_op("0/5", W'(0), W'(5));
  endtask

  // A second start during CALC is ignored; then reset abandons an operation.
  task automatic test_ignore_and_reset();
    int lat = -1;
    int npulse = 0;
    logic [W-1:0] qo = '0;
    logic [W-1:0] ro = '0;
    @(negedge clk);
    x = W'(91); y = W'(10); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= int'(W) + 3; k++) begin
      if (k == 5) begin
        x = W'(7); y = W'(2); start = 1'b1;
      end
      @(posedge clk); #1;
      if (k == 5) start = 1'b0;
      if (out_en) begin
        npulse++;
        if (lat < 0) begin lat = k; qo = q; ro = r; end
      end
    end
    checks++;
    if (lat !== int'(W) || npulse !== 1) begin
      errors++; $display("FAIL ignore latency/pulses: got %0d/%0d expected %0d/1", lat, npulse, W);
    end
    checks++;
    if (qo !== W'(9) || ro !== W'(1)) begin
      errors++; $display("FAIL ignore q/r: got %0h/%0h expected 9/1", qo, ro);
    end

    @(negedge clk);
    x = W'(91); y = W'(10); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q !== '0 || r !== '0 || busy !== 1'b0 || out_en !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got q=%0h r=%0h busy=%0b oe=%0b dz=%0b expected all 0",
               q, r, busy, out_en, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    npulse = 0;
    for (int k = 0; k < int'(W) + 8; k++) begin
      @(posedge clk); #1;
      if (out_en) npulse++;
    end
    checks++;
    if (npulse !== 0) begin
      errors++; $display("FAIL abandoned op pulses: got %0d expected 0", npulse);
    end
    last_q = '0;
    last_r = '0;
    test_op("after reset 100/3", W'(100), W'(3));
  endtask

  // start held high; operands switched during the first DONE cycle.
  task automatic test_back_to_back();
    int pk[$];
    logic [W-1:0] pq[$];
    logic [W-1:0] pr[$];
    @(negedge clk);
    x = W'(91); y = W'(10); start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 2 * int'(W) + 12; k++) begin
      @(posedge clk); #1;
      if (out_en) begin
        pk.push_back(k); pq.push_back(q); pr.push_back(r);
        if (pk.size() == 1) begin
          x = W'(50); y = W'(7);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (pk.size() !== 2) begin
      errors++; $display("FAIL b2b pulse count: got %0d expected 2", pk.size());
    end else begin
      checks++;
      if (pk[0] !== int'(W) || pk[1] !== 2 * int'(W) + 1) begin
        errors++;
        $display("FAIL b2b pulse edges: got %0d,%0d expected %0d,%0d", pk[0], pk[1], W, 2 * W + 1);
      end
      checks++;
      if (pq[0] !== W'(9) || pr[0] !== W'(1) || pq[1] !== W'(7) || pr[1] !== W'(1)) begin
        errors++;
        $display("FAIL b2b q/r: got %0h/%0h %0h/%0h expected 9/1 7/1", pq[0], pr[0], pq[1], pr[1]);
      end
    end
    last_q = W'(7);
    last_r = W'(1);
  endtask

  task automatic test_random();
    logic [W-1:0] xv, yv;
    int sel;
    for (int i = 0; i < 24; i++) begin
      xv  = W'($urandom);
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       yv = '0;
        1:       yv = W'($urandom_range(1, 15));
        2:       yv = W'($urandom) | W'(24'h800000);
        default: yv = W'($urandom) >> $urandom_range(0, W - 1);
      endcase
      test_op("random", xv, yv);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb_divisor();
    test_div_zero();
    test_ignore_and_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
